// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_param
//  Brief    : Parametrised single-write, dual-read register file.
//             Reads are registered (one-cycle latency) and occur every cycle.
//             A write to the address being read is bypassed, so the read
//             returns the new data. A clear sequencer zeroes one entry per
//             cycle after reset or on Clr_Req, so the storage needs no
//             parallel reset and can map onto RAM. Busy is high while the
//             sweep runs.
//  Options  : REGFILE_ZERO_REG_EN - when defined, entry 0 is hardwired to
//             zero. Writes to it are dropped and reads of it return 0.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clr_Req,
  input  logic              Write_Reg,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] Data,
  input  logic [ADDR_W-1:0] R_Addr_A,
  input  logic [ADDR_W-1:0] R_Addr_B,
  output logic [DATA_W-1:0] R_Data_A,
  output logic [DATA_W-1:0] R_Data_B,
  output logic              Busy
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

`ifdef REGFILE_ZERO_REG_EN
  localparam logic ZERO_REG = 1'b1;
`else
  localparam logic ZERO_REG = 1'b0;
`endif

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_idx;
  logic [ADDR_W-1:0] clr_idx_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_addr_ok;
  logic              wr_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_val_a;
  logic [DATA_W-1:0] rd_val_b;

  // Clear-sequencer state and sweep index register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  // Next-state logic: sweep every entry, then wait in READY for Clr_Req
  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    case (state)
      CLEAR: begin
        clr_idx_nxt = clr_idx + ADDR_W'(1);
        if (clr_idx == LAST_IDX) begin
          state_nxt = READY;
        end
      end
      READY: begin
        if (Clr_Req) begin
          state_nxt   = CLEAR;
          clr_idx_nxt = '0;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_idx_nxt = '0;
      end
    endcase
  end

  // Busy follows the registered state, so it is glitch-free
  assign Busy = (state == CLEAR);

  // User write qualification: Clr_Req wins over a simultaneous write, and
  // the hardwired-zero entry (when enabled) silently drops writes
  always_comb begin
    wr_addr_ok = !(ZERO_REG && (Addr == '0));
    wr_en      = (state == READY) && !Clr_Req && Write_Reg && wr_addr_ok;
  end

  // Single storage write port shared by the sweep and user writes
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = Addr;
    mem_wdata = Data;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_idx;
      mem_wdata = '0;
    end else if (wr_en) begin
      mem_we    = 1'b1;
      mem_waddr = Addr;
      mem_wdata = Data;
    end
  end

  // Storage array: no reset, a reset edge simply suppresses the write
  always_ff @(posedge Clk) begin
    if (!Reset && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read-side mux: write-first bypass, then the optional zero entry
  always_comb begin
    rd_val_a = mem[R_Addr_A];
    rd_val_b = mem[R_Addr_B];
    if (wr_en && (R_Addr_A == Addr)) begin
      rd_val_a = Data;
    end
    if (wr_en && (R_Addr_B == Addr)) begin
      rd_val_b = Data;
    end
    if (ZERO_REG && (R_Addr_A == '0)) begin
      rd_val_a = '0;
    end
    if (ZERO_REG && (R_Addr_B == '0)) begin
      rd_val_b = '0;
    end
  end

  // Registered read outputs, held at zero during reset and the sweep
  always_ff @(posedge Clk) begin
    if (Reset || (state == CLEAR)) begin
      R_Data_A <= '0;
      R_Data_B <= '0;
    end else begin
      R_Data_A <= rd_val_a;
      R_Data_B <= rd_val_b;
    end
  end

endmodule
`default_nettype wire
